// File: rtl/pid_lock_sequencer_if.sv
// ----------------------------------------------------------------------------
// pid_lock_sequencer_if
// Groups the register-bank and datapath signals of one PID lock sequencer.
// Signal suffixes are written from the sequencer's point of view.
//   slave  modport : the sequencer itself
//   master modport : register bank / datapath / testbench side
// Optional: PID_LOCK_SEQ_TIMEOUT_EN adds search_timeout_i.
// ----------------------------------------------------------------------------
interface pid_lock_sequencer_if #(
    parameter int CNT_BITS   = 24,
    parameter int RETRY_BITS = 8,
    parameter int LOSS_BITS  = 16
);
    logic                  enable_i;
    logic                  near_res_i;
    logic [1:0]            railed_i;
    logic [CNT_BITS-1:0]   settle_cycles_i;
    logic [CNT_BITS-1:0]   lost_cycles_i;
    logic [RETRY_BITS-1:0] max_retries_i;
    logic                  ack_fault_i;
`ifdef PID_LOCK_SEQ_TIMEOUT_EN
    logic [CNT_BITS-1:0]   search_timeout_i;
`endif
    logic                  relock_on_o;
    logic                  pid_hold_o;
    logic                  int_clear_o;
    logic                  locked_o;
    logic [2:0]            state_o;
    logic [RETRY_BITS-1:0] retry_cnt_o;
    logic [LOSS_BITS-1:0]  loss_cnt_o;

    modport slave (
`ifdef PID_LOCK_SEQ_TIMEOUT_EN
        input  search_timeout_i,
`endif
        input  enable_i, near_res_i, railed_i, settle_cycles_i, lost_cycles_i,
               max_retries_i, ack_fault_i,
        output relock_on_o, pid_hold_o, int_clear_o, locked_o, state_o,
               retry_cnt_o, loss_cnt_o
    );

    modport master (
`ifdef PID_LOCK_SEQ_TIMEOUT_EN
        output search_timeout_i,
`endif
        output enable_i, near_res_i, railed_i, settle_cycles_i, lost_cycles_i,
               max_retries_i, ack_fault_i,
        input  relock_on_o, pid_hold_o, int_clear_o, locked_o, state_o,
               retry_cnt_o, loss_cnt_o
    );
endinterface

// File: rtl/pid_lock_sequencer.sv
// ----------------------------------------------------------------------------
// pid_lock_sequencer
// Lock-acquisition supervisor for one PID channel: drives the relock sweep,
// integrator hold/clear, qualifies lock from the near-resonance flag,
// debounces lock loss, counts losses and faults after too many retries.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : enable/near_res/railed/timing/retry-limit/ack inputs,
//                  relock_on/pid_hold/int_clear/locked/state/counters outputs
// Optional: PID_LOCK_SEQ_TIMEOUT_EN enables a SEARCH timeout that counts as
// a failed attempt and restarts the sweep.
//
// state  | meaning
// IDLE   | disabled, all outputs low
// SEARCH | sweep running, integrator held
// SETTLE | in window, waiting settle_cycles_i of dwell
// LOCKED | qualified lock
// LOST   | out of window, debouncing before declaring a loss
// FAULT  | retry limit reached, waiting for ack_fault_i
// ----------------------------------------------------------------------------
module pid_lock_sequencer #(
    parameter int CNT_BITS   = 24,
    parameter int RETRY_BITS = 8,
    parameter int LOSS_BITS  = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    pid_lock_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        SETTLE = 3'd2,
        LOCKED = 3'd3,
        LOST   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   timer_q, timer_d;
    logic [RETRY_BITS-1:0] retry_q, retry_d, retry_inc;
    logic [LOSS_BITS-1:0]  loss_q, loss_d;
    logic                  relock_q, relock_d;
    logic                  hold_q, hold_d;
    logic                  clear_q, clear_d;
    logic                  locked_q, locked_d;
    logic                  restart;      // SEARCH re-entered after a timeout
    logic                  retry_limit;

    assign retry_inc   = (&retry_q) ? retry_q : retry_q + 1'b1;
    // Limit is judged on the incremented count, i.e. the value after this failure.
    assign retry_limit = (bus.max_retries_i != '0) && (retry_inc >= bus.max_retries_i);

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        loss_d   = loss_q;
        clear_d  = 1'b0;
        restart  = 1'b0;
        relock_d = 1'b0;
        hold_d   = 1'b0;
        locked_d = 1'b0;
        timer_d  = '0;

        if (!bus.enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                    clear_d = 1'b1;
                end
                SEARCH: begin
                    if (bus.near_res_i) begin
                        state_d = SETTLE;
                    end
`ifdef PID_LOCK_SEQ_TIMEOUT_EN
                    else if ((bus.search_timeout_i != '0) &&
                             (timer_q >= bus.search_timeout_i)) begin
                        retry_d = retry_inc;
                        clear_d = 1'b1;
                        restart = 1'b1;
                        state_d = retry_limit ? FAULT : SEARCH;
                    end
`endif
                end
                SETTLE: begin
                    if (!bus.near_res_i) begin
                        state_d = SEARCH;
                    end else if (timer_q >= bus.settle_cycles_i) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    // A full settle dwell in lock means the last attempt succeeded.
                    if (timer_q == bus.settle_cycles_i) begin
                        retry_d = '0;
                    end
                    if (!bus.near_res_i) begin
                        state_d = LOST;
                    end
                end
                LOST: begin
                    if (bus.near_res_i) begin
                        state_d = LOCKED;
                    end else if (timer_q >= bus.lost_cycles_i) begin
                        loss_d  = (&loss_q) ? loss_q : loss_q + 1'b1;
                        retry_d = retry_inc;
                        if (retry_limit) begin
                            state_d = FAULT;
                            clear_d = 1'b1;
                        end else begin
                            state_d = SEARCH;
                            clear_d = |bus.railed_i;
                        end
                    end
                end
                FAULT: begin
                    if (bus.ack_fault_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) begin
            retry_d = '0;
        end

        // Outputs are registered, so they are decoded from the next state.
        case (state_d)
            SEARCH: begin
                relock_d = !restart;
                hold_d   = 1'b1;
            end
            SETTLE: relock_d = 1'b1;
            LOCKED, LOST: begin
                relock_d = 1'b1;
                locked_d = 1'b1;
            end
            FAULT:   hold_d = 1'b1;
            default: ;
        endcase

        if ((state_d != state_q) || restart) begin
            timer_d = '0;
        end else begin
            timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            retry_q  <= '0;
            loss_q   <= '0;
            relock_q <= 1'b0;
            hold_q   <= 1'b0;
            clear_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            relock_q <= relock_d;
            hold_q   <= hold_d;
            clear_q  <= clear_d;
            locked_q <= locked_d;
        end
    end

    assign bus.relock_on_o = relock_q;
    assign bus.pid_hold_o  = hold_q;
    assign bus.int_clear_o = clear_q;
    assign bus.locked_o    = locked_q;
    assign bus.state_o     = state_q;
    assign bus.retry_cnt_o = retry_q;
    assign bus.loss_cnt_o  = loss_q;
endmodule

// File: tb/tb_pid_lock_sequencer.sv
module tb_pid_lock_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_SEARCH = 3'd1, S_SETTLE = 3'd2,
                           S_LOCKED = 3'd3, S_LOST = 3'd4, S_FAULT = 3'd5;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [7:0] retry;
        logic [15:0] loss;
        logic       clr, relock, locked, hold;
    } ev_t;

    logic clk, rst;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    ev_t  q[$];
    ev_t  r_mon, last_ev;
    logic [2:0] prev_state = 3'd0;

    // Model of the sequencer at episode level
    int         S, L, M, eL;
    logic [7:0] m_retry = 0;
    logic [15:0] m_loss = 0;
    bit         m_fault = 0;

    pid_lock_sequencer_if #(.CNT_BITS(24), .RETRY_BITS(8), .LOSS_BITS(16)) sif();
    pid_lock_sequencer #(.CNT_BITS(24), .RETRY_BITS(8), .LOSS_BITS(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus(sif));

    initial begin clk = 0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic void push(int c, logic [2:0] st, logic clr, logic relock,
                                 logic locked, logic hold);
        ev_t r;
        r.cyc = c; r.st = st; r.retry = m_retry; r.loss = m_loss;
        r.clr = clr; r.relock = relock; r.locked = locked; r.hold = hold;
        q.push_back(r);
    endfunction

    // Monitor: every state change or int_clear pulse is an observable event.
    initial begin
        last_ev.cyc = 0; last_ev.st = 0; last_ev.retry = 0; last_ev.loss = 0;
        last_ev.clr = 0; last_ev.relock = 0; last_ev.locked = 0; last_ev.hold = 0;
    end
    always @(negedge clk) begin
        if ((sif.state_o != prev_state) || sif.int_clear_o) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_event: actual state %0d clear %0b required no event (cycle %0d)",
                         sif.state_o, sif.int_clear_o, cyc);
            end else begin
                r_mon = q.pop_front();
                chk("ev_cycle", cyc, r_mon.cyc);
                chk("ev_state", sif.state_o, r_mon.st);
                chk("ev_retry_cnt", sif.retry_cnt_o, r_mon.retry);
                chk("ev_loss_cnt", sif.loss_cnt_o, r_mon.loss);
                chk("ev_int_clear", sif.int_clear_o, r_mon.clr);
                chk("ev_relock_on", sif.relock_on_o, r_mon.relock);
                chk("ev_locked", sif.locked_o, r_mon.locked);
                chk("ev_pid_hold", sif.pid_hold_o, r_mon.hold);
                last_ev = r_mon;
            end
        end else begin
            chk("steady_locked", sif.locked_o, last_ev.locked);
            chk("steady_pid_hold", sif.pid_hold_o, last_ev.hold);
        end
        prev_state = sif.state_o;
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic wait_until(input int e); while (cyc < e) tick(); endtask

    // In SEARCH now and at the next edge: raise near_res, reach LOCKED.
    task automatic acquire(input bit glitch);
        int e1, x;
        bit g;
        g = glitch;
        forever begin
            e1 = cyc;
            sif.near_res_i = 1;
            push(e1 + 1, S_SETTLE, 0, 1, 0, 0);
            if (g && S >= 1) begin
                x = e1 + 1 + int'($urandom_range(0, S - 1));
                wait_until(x);
                sif.near_res_i = 0;
                push(x + 1, S_SEARCH, 0, 1, 0, 1);
                wait_until(x + 1);
                g = 0;
            end else begin
                eL = e1 + S + 2;
                push(eL, S_LOCKED, 0, 1, 1, 0);
                wait_until(eL);
                break;
            end
        end
    endtask

    task automatic start_seq(input bit glitch);
        int e0;
        e0 = cyc;
        sif.enable_i = 1;
        m_retry = 0;
        push(e0 + 1, S_SEARCH, 1, 1, 0, 1);
        wait_until(e0 + 1 + int'($urandom_range(1, 4)));
        acquire(glitch);
    endtask

    // In LOCKED: dwell w cycles, then hold near_res low for k cycles.
    task automatic drop(input int k, input int w, input logic [1:0] rl);
        int g, el;
        g = eL + ((w == S) ? w + 1 : w);
        if (g >= eL + 2) begin
            sif.ack_fault_i = 1;      // must be ignored outside FAULT
            wait_until(eL + 1);
            sif.ack_fault_i = 0;
        end
        wait_until(g);
        if (g >= eL + S) m_retry = 0;
        sif.railed_i = rl;
        sif.near_res_i = 0;
        push(g + 1, S_LOST, 0, 1, 1, 0);
        if (k <= L + 1) begin
            wait_until(g + k);
            sif.near_res_i = 1;
            eL = g + k + 1;
            push(eL, S_LOCKED, 0, 1, 1, 0);
            wait_until(eL);
        end else begin
            el = g + L + 2;
            if (m_loss != 16'hFFFF) m_loss = m_loss + 1;
            if (m_retry != 8'hFF) m_retry = m_retry + 1;
            if (M != 0 && m_retry >= M) begin
                push(el, S_FAULT, 1, 0, 0, 1);
                m_fault = 1;
                wait_until(el);
            end else begin
                push(el, S_SEARCH, (rl != 0), 1, 0, 1);
                wait_until(g + k);
                acquire($urandom_range(0, 1) == 1);
            end
        end
    endtask

    task automatic fault_ack();
        int f;
        f = cyc + int'($urandom_range(0, 3));
        wait_until(f);
        sif.ack_fault_i = 1;
        m_retry = 0;
        push(f + 1, S_IDLE, 0, 0, 0, 0);
        push(f + 2, S_SEARCH, 1, 1, 0, 1);
        wait_until(f + 1);
        sif.ack_fault_i = 0;
        m_fault = 0;
        wait_until(f + 2 + int'($urandom_range(1, 3)));
        acquire(0);
    endtask

    task automatic disable_now();
        int d;
        d = cyc;
        sif.enable_i = 0;
        sif.near_res_i = 0;
        m_retry = 0;
        push(d + 1, S_IDLE, 0, 0, 0, 0);
        wait_until(d + 2);
    endtask

    task automatic set_cfg(input int s, input int l, input int m);
        S = s; L = l; M = m;
        sif.settle_cycles_i = 24'(s);
        sif.lost_cycles_i   = 24'(l);
        sif.max_retries_i   = 8'(m);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, sif.state_o, 0);
        chk({tag, "_relock_on"}, sif.relock_on_o, 0);
        chk({tag, "_pid_hold"}, sif.pid_hold_o, 0);
        chk({tag, "_int_clear"}, sif.int_clear_o, 0);
        chk({tag, "_locked"}, sif.locked_o, 0);
        chk({tag, "_retry_cnt"}, sif.retry_cnt_o, 0);
        chk({tag, "_loss_cnt"}, sif.loss_cnt_o, 0);
    endtask

    initial begin
        int e0, e1, k, w;
        rst = 1;
        sif.enable_i = 0; sif.near_res_i = 0; sif.railed_i = 0; sif.ack_fault_i = 0;
`ifdef PID_LOCK_SEQ_TIMEOUT_EN
        sif.search_timeout_i = 0;
`endif
        set_cfg(10, 10, 0);
        #2;
        check_all_zero("reset");
        repeat (3) tick();
        rst = 0;
        tick();

        // Randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            set_cfg(int'($urandom_range(0, 40)), int'($urandom_range(0, 30)),
                    int'($urandom_range(0, 3)));
            start_seq($urandom_range(0, 1) == 1);
            for (int n = 0; n < 4 && !m_fault; n++) begin
                k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, L + 1))
                                                : int'($urandom_range(L + 2, L + 20));
                w = int'($urandom_range(0, 2 * S + 3));
                drop(k, w, 2'($urandom_range(0, 3)));
            end
            if (m_fault) fault_ack();
            disable_now();
        end

        // Directed: settle=100, lost=50, glitch of 30 then a real loss with railed high
        set_cfg(100, 50, 0);
        start_seq(0);
        drop(30, 5, 2'b00);
        drop(60, 5, 2'b10);
        disable_now();

        // Directed: two quick losses with max_retries=2 reach FAULT
        set_cfg(20, 5, 2);
        start_seq(0);
        drop(10, 3, 2'b00);
        drop(10, 3, 2'b00);
        if (m_fault) fault_ack();
        disable_now();

        // Directed: asynchronous reset in the middle of SETTLE
        set_cfg(int'($urandom_range(5, 30)), 10, 0);
        e0 = cyc;
        sif.enable_i = 1;
        push(e0 + 1, S_SEARCH, 1, 1, 0, 1);
        wait_until(e0 + 2);
        e1 = cyc;
        sif.near_res_i = 1;
        push(e1 + 1, S_SETTLE, 0, 1, 0, 0);
        wait_until(e1 + 3);
        m_retry = 0;
        m_loss = 0;
        push(cyc, S_IDLE, 0, 0, 0, 0);
        #2 rst = 1;
        #1 check_all_zero("async_rst");
        sif.enable_i = 0;
        sif.near_res_i = 0;
        tick();
        tick();
        rst = 0;
        tick();

`ifdef PID_LOCK_SEQ_TIMEOUT_EN
        begin
            int T;
            set_cfg(10, 10, 0);
            T = int'($urandom_range(5, 20));
            sif.search_timeout_i = 24'(T);
            e0 = cyc;
            sif.enable_i = 1;
            m_retry = 0;
            push(e0 + 1, S_SEARCH, 1, 1, 0, 1);
            for (int n = 1; n <= 3; n++) begin
                m_retry = m_retry + 1;
                push(e0 + 1 + n * (T + 1), S_SEARCH, 1, 0, 0, 1);
            end
            wait_until(e0 + 2 + 3 * (T + 1));
            chk("timeout_relock_back", sif.relock_on_o, 1);
            disable_now();
            sif.search_timeout_i = 0;
        end
`endif

        repeat (5) tick();
        chk("pending_events", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
